// File: rtl/axicb_pkg.sv
// Shared crossbar definitions: master index sizing and the index type.
package axicb_pkg;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned MST_NB_DFLT = 4;
  localparam int unsigned MST_IDX_W   = idx_width(MST_NB_DFLT);

  typedef logic [MST_IDX_W-1:0] mst_idx_t;

endpackage

// File: rtl/axicb_slv_wr_arbiter_if.sv
// AW/W bundle between the master switches and one slave port.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface axicb_slv_wr_arbiter_if #(
  parameter int unsigned MST_NB = 4,
  parameter int unsigned AWCH_W = 8,
  parameter int unsigned WCH_W  = 8
);
  logic [MST_NB-1:0]        i_awvalid;
  logic [MST_NB-1:0]        i_awready;
  logic [MST_NB*AWCH_W-1:0] i_awch;
  logic [MST_NB-1:0]        i_wvalid;
  logic [MST_NB-1:0]        i_wready;
  logic [MST_NB-1:0]        i_wlast;
  logic [MST_NB*WCH_W-1:0]  i_wch;
  logic                     o_awvalid;
  logic                     o_awready;
  logic [AWCH_W-1:0]        o_awch;
  logic                     o_wvalid;
  logic                     o_wready;
  logic                     o_wlast;
  logic [WCH_W-1:0]         o_wch;

  modport slave (
    input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, o_awready, o_wready,
    output i_awready, i_wready, o_awvalid, o_awch, o_wvalid, o_wlast, o_wch
  );

  modport master (
    output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, o_awready, o_wready,
    input  i_awready, i_wready, o_awvalid, o_awch, o_wvalid, o_wlast, o_wch
  );
endinterface

// File: rtl/axicb_order_fifo.sv
// Synchronous FIFO holding AW acceptance order; caller never pushes when full or pops when empty.
module axicb_order_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; entries are only read behind a valid count, so reset logic would be wasted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/axicb_round_robin.sv
// Round-robin arbiter: one-hot grant, priority moves past the winner when en is set.
module axicb_round_robin
  import axicb_pkg::*;
#(
  parameter int unsigned REQ_NB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              srst,
  input  logic              en,
  input  logic [REQ_NB-1:0] req,
  output logic [REQ_NB-1:0] grant
);

  localparam int unsigned IDX_W = idx_width(REQ_NB);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             found;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < int'(REQ_NB); i++) begin
      j = (int'(ptr) + i) % int'(REQ_NB);
      if (!found && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        found     = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (srst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (grant_idx == IDX_W'(REQ_NB - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axicb_slv_wr_arbiter.sv
// Shares one slave's AW/W channels among the master switches; W bursts follow AW acceptance order.
module axicb_slv_wr_arbiter
  import axicb_pkg::*;
#(
  parameter int unsigned MST_NB      = MST_NB_DFLT,
  parameter int unsigned AWCH_W      = 8,
  parameter int unsigned WCH_W       = 8,
  parameter int unsigned OSTDREQ_NUM = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   srst,
  axicb_slv_wr_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(MST_NB);

  logic [MST_NB-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  head;
  logic              full;
  logic              empty;
  logic              aw_hs;
  logic              w_pop;
  logic [AWCH_W-1:0] aw_payload;
  logic              w_valid;
  logic              w_last;
  logic [WCH_W-1:0]  w_payload;
  logic [MST_NB-1:0] w_ready;

  axicb_round_robin #(
    .REQ_NB (MST_NB)
  ) u_rr (
    .clk   (aclk),
    .rst_n (aresetn),
    .srst  (srst),
    .en    (aw_hs),
    .req   (bus.i_awvalid),
    .grant (grant)
  );

  always_comb begin
    grant_idx  = '0;
    aw_payload = '0;
    for (int k = 0; k < int'(MST_NB); k++) begin
      if (grant[k]) grant_idx = IDX_W'(k);
    end
    for (int k = 0; k < int'(MST_NB); k++) begin
      if (grant_idx == IDX_W'(k)) aw_payload = bus.i_awch[k*AWCH_W +: AWCH_W];
    end
  end

  // Full blocks AW even when a pop lands the same cycle; the slot is reused next cycle.
  assign bus.o_awvalid = (|bus.i_awvalid) & ~full;
  assign bus.o_awch    = aw_payload;
  assign bus.i_awready = grant & {MST_NB{bus.o_awready & ~full}};
  assign aw_hs         = bus.o_awvalid & bus.o_awready;

  axicb_order_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (OSTDREQ_NUM)
  ) u_order (
    .clk   (aclk),
    .rst_n (aresetn),
    .srst  (srst),
    .push  (aw_hs),
    .wdata (grant_idx),
    .pop   (w_pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Only the FIFO-head master sees W ready, so bursts never interleave.
  always_comb begin
    w_valid   = 1'b0;
    w_last    = 1'b0;
    w_payload = '0;
    w_ready   = '0;
    for (int k = 0; k < int'(MST_NB); k++) begin
      if (head == IDX_W'(k)) begin
        w_valid    = bus.i_wvalid[k];
        w_last     = bus.i_wlast[k];
        w_payload  = bus.i_wch[k*WCH_W +: WCH_W];
        w_ready[k] = bus.o_wready & ~empty;
      end
    end
  end

  assign bus.o_wvalid = w_valid & ~empty;
  assign bus.o_wlast  = w_last;
  assign bus.o_wch    = w_payload;
  assign bus.i_wready = w_ready;
  assign w_pop        = bus.o_wvalid & bus.o_wready & bus.o_wlast;

endmodule
